// File: rtl/vae_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vae_pkg                                                          |
// | Brief   : Shared constants, FSM encoding and slot helper for the VAE path  |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package vae_pkg;

   localparam int C_DEF_N_IN  = 9;
   localparam int C_DEF_WIDTH = 16;

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_PAD  = 1'b1;

   // Slot 0 is the newest word and sits at the LSB end of the window.
   function automatic int slot_lsb(input int slot, input int width);
      return slot * width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_shift_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sipo_shift_core                                                  |
// | Brief   : N_IN x WIDTH shift register, new word enters slot 0 (LSB)        |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sipo_shift_core
   import vae_pkg::*;
#(
   parameter int N_IN  = C_DEF_N_IN,
   parameter int WIDTH = C_DEF_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    shift_en,
   input  logic                    zero_ins,
   input  logic [WIDTH-1:0]        din,
   output logic [N_IN*WIDTH-1:0]   sreg
);

   localparam int c_keep_bits = slot_lsb(N_IN - 1, WIDTH);

   logic [N_IN*WIDTH-1:0] r_sreg;
   logic [WIDTH-1:0]      w_head;

   assign w_head = zero_ins ? '0 : din;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sreg <= '0;
      end else if (shift_en) begin
         r_sreg <= {r_sreg[c_keep_bits-1:0], w_head};
      end
   end

   assign sreg = r_sreg;

endmodule
`default_nettype wire

// File: rtl/sipo_window_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sipo_window_buf                                                  |
// | Brief   : Serial-in/parallel-out window buffer with stride and frame pad   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sipo_window_buf
   import vae_pkg::*;
#(
   parameter int N_IN   = C_DEF_N_IN,
   parameter int WIDTH  = C_DEF_WIDTH,
   parameter int STRIDE = C_DEF_N_IN
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            in_data,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [N_IN*WIDTH-1:0]       out_data,
   output logic                        out_last,
   output logic [$clog2(N_IN+1)-1:0]   fill_level
);

   localparam int              c_fw   = $clog2(N_IN + 1);
   localparam logic [c_fw-1:0] c_full = c_fw'(N_IN);
   localparam logic [c_fw-1:0] c_keep = c_fw'(N_IN - STRIDE);
   localparam logic [c_fw-1:0] c_one  = c_fw'(1);

   logic [0:0]            r_state;
   logic [c_fw-1:0]       r_fill;
   logic                  r_last_pend;
   logic                  r_out_valid;
   logic [N_IN*WIDTH-1:0] r_out_data;
   logic                  r_out_last;

   logic [N_IN*WIDTH-1:0] w_sreg;
   logic                  w_accept;
   logic                  w_xfer;
   logic                  w_pad;
   logic                  w_shift;
   logic [c_fw-1:0]       w_fill_base;
   logic [c_fw-1:0]       w_fill_step;
   logic [0:0]            w_state_nxt;

   sipo_shift_core #(
      .N_IN  (N_IN),
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .shift_en (w_shift),
      .zero_ins (w_pad),
      .din      (in_data),
      .sreg     (w_sreg)
   );

   // in_ready depends on out_ready through w_xfer, never on in_valid.
   assign w_xfer   = (r_fill == c_full) & (~r_out_valid | out_ready);
   assign in_ready = (r_state == ST_FILL) & ~r_last_pend & ((r_fill < c_full) | w_xfer);
   assign w_accept = in_valid & in_ready;
   assign w_pad    = (r_state == ST_PAD);
   assign w_shift  = (w_accept | w_pad) & ~clear;

   // A frame-final window drops all overlap so the next frame starts empty.
   assign w_fill_base = w_xfer ? (r_last_pend ? '0 : c_keep) : r_fill;
   assign w_fill_step = (w_accept | w_pad) ? (w_fill_base + c_one) : w_fill_base;

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = ST_FILL;
      end else if (r_state == ST_FILL) begin
         if (w_accept && in_last && (w_fill_step < c_full)) begin
            w_state_nxt = ST_PAD;
         end
      end else if (w_fill_step == c_full) begin
         w_state_nxt = ST_FILL;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_FILL;
         r_fill      <= '0;
         r_last_pend <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (clear) begin
            r_fill      <= '0;
            r_last_pend <= 1'b0;
         end else begin
            r_fill <= w_fill_step;
            if (w_xfer && r_last_pend) begin
               r_last_pend <= 1'b0;
            end else if (w_accept && in_last) begin
               r_last_pend <= 1'b1;
            end
         end
      end
   end

   // Output register is untouched by clear so a presented window survives it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_sreg;
         r_out_last  <= r_last_pend;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_last   = r_out_last;
   assign fill_level = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_sipo_window_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sipo_window_buf                                               |
// | Brief   : Scoreboard bench for sipo_window_buf (default and 3/8/1 configs) |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_sipo_window_buf;

   typedef struct {
      logic [143:0] data;
      logic         last;
   } win_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic          a_clear = 1'b0, a_in_valid = 1'b0, a_in_last = 1'b0, a_out_ready = 1'b1;
   logic [15:0]   a_in_data = '0;
   logic          a_in_ready, a_out_valid, a_out_last;
   logic [143:0]  a_out_data;
   logic [3:0]    a_fill_level;

   logic          b_clear = 1'b0, b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b1;
   logic [7:0]    b_in_data = '0;
   logic          b_in_ready, b_out_valid, b_out_last;
   logic [23:0]   b_out_data;
   logic [1:0]    b_fill_level;

   int n_tests = 0;
   int n_fail  = 0;

   win_t        qa[$];
   win_t        qb[$];
   logic [15:0] ha[$];
   logic [7:0]  hb[$];

   always #5 clk = ~clk;

   sipo_window_buf dut_a (
      .clk(clk), .rst(rst), .clear(a_clear),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_last(a_out_last), .fill_level(a_fill_level)
   );

   sipo_window_buf #(.N_IN(3), .WIDTH(8), .STRIDE(1)) dut_b (
      .clk(clk), .rst(rst), .clear(b_clear),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_last(b_out_last), .fill_level(b_fill_level)
   );

   task automatic check_eq(input string tag, input logic [143:0] act, input logic [143:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference window model: oldest word ends up in the most significant slot.
   function automatic void model_a(input logic [15:0] w, input logic last);
      win_t e;
      ha.push_back(w);
      if (last) while (ha.size() < 9) ha.push_back(16'h0);
      if (ha.size() == 9) begin
         e.data = '0;
         foreach (ha[i]) e.data = (e.data << 16) | 144'(ha[i]);
         e.last = last;
         qa.push_back(e);
         if (last) ha.delete();
         else for (int i = 0; i < 9; i++) void'(ha.pop_front());
      end
   endfunction

   function automatic void model_b(input logic [7:0] w, input logic last);
      win_t e;
      hb.push_back(w);
      if (last) while (hb.size() < 3) hb.push_back(8'h0);
      if (hb.size() == 3) begin
         e.data = '0;
         foreach (hb[i]) e.data = (e.data << 8) | 144'(hb[i]);
         e.last = last;
         qb.push_back(e);
         if (last) hb.delete();
         else void'(hb.pop_front());
      end
   endfunction

   function automatic logic [143:0] pack_a(input int first);
      logic [143:0] v = '0;
      for (int i = 0; i < 9; i++) v = (v << 16) | 144'(first + i);
      return v;
   endfunction

   always @(negedge clk) begin
      win_t e;
      if (!rst && a_out_valid && a_out_ready) begin
         check_eq("a_sb_nonempty", 144'(qa.size() != 0), 144'd1);
         if (qa.size() != 0) begin
            e = qa.pop_front();
            check_eq("a_win_data", a_out_data, e.data);
            check_eq("a_win_last", 144'(a_out_last), 144'(e.last));
         end
      end
   end

   always @(negedge clk) begin
      win_t e;
      if (!rst && b_out_valid && b_out_ready) begin
         check_eq("b_sb_nonempty", 144'(qb.size() != 0), 144'd1);
         if (qb.size() != 0) begin
            e = qb.pop_front();
            check_eq("b_win_data", 144'(b_out_data), e.data);
            check_eq("b_win_last", 144'(b_out_last), 144'(e.last));
         end
      end
   end

   task automatic send_a(input logic [15:0] w, input logic last, output int waits);
      logic acc;
      waits = 0;
      a_in_valid = 1'b1; a_in_data = w; a_in_last = last;
      forever begin
         @(negedge clk); acc = a_in_ready;
         @(posedge clk);
         if (acc) break;
         waits++;
         if (waits > 200) begin
            check_eq("a_send_timeout", 144'(waits), 144'd200);
            break;
         end
      end
      if (acc) model_a(w, last);
      #1; a_in_valid = 1'b0; a_in_last = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] w, input logic last, output int waits);
      logic acc;
      waits = 0;
      b_in_valid = 1'b1; b_in_data = w; b_in_last = last;
      forever begin
         @(negedge clk); acc = b_in_ready;
         @(posedge clk);
         if (acc) break;
         waits++;
         if (waits > 200) begin
            check_eq("b_send_timeout", 144'(waits), 144'd200);
            break;
         end
      end
      if (acc) model_b(w, last);
      #1; b_in_valid = 1'b0; b_in_last = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #3;
      rst = 1'b1;
      a_in_valid = 1'b0; b_in_valid = 1'b0;
      qa.delete(); ha.delete(); qb.delete(); hb.delete();
      #1;
      check_eq("rst_out_valid", 144'(a_out_valid), 144'd0);
      check_eq("rst_out_data", a_out_data, 144'd0);
      check_eq("rst_out_last", 144'(a_out_last), 144'd0);
      check_eq("rst_fill", 144'(a_fill_level), 144'd0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wt, tot;
      #2;
      check_eq("init_out_valid", 144'(a_out_valid), 144'd0);
      check_eq("init_out_data", a_out_data, 144'd0);
      check_eq("init_fill", 144'(a_fill_level), 144'd0);
      check_eq("init_in_ready", 144'(a_in_ready), 144'd1);
      @(posedge clk); #1; rst = 1'b0;

      // Single window, latency and fill after transfer
      for (int i = 1; i <= 9; i++) send_a(16'(i), 1'b0, wt);
      @(negedge clk);
      check_eq("t1_valid_lat0", 144'(a_out_valid), 144'd0);
      @(negedge clk);
      check_eq("t1_valid_lat1", 144'(a_out_valid), 144'd1);
      check_eq("t1_lsb_word", 144'(a_out_data[15:0]), 144'd9);
      check_eq("t1_msb_word", 144'(a_out_data[143:128]), 144'd1);
      check_eq("t1_fill", 144'(a_fill_level), 144'd0);

      // Sustained one word per cycle across window boundaries
      @(posedge clk); #1;
      tot = 0;
      for (int i = 1; i <= 18; i++) begin
         send_a(16'(i), 1'b0, wt);
         tot += wt;
      end
      check_eq("t2_no_stall", 144'(tot), 144'd0);
      repeat (5) @(posedge clk);

      // Overlapping windows on the 3/8/1 instance
      #1;
      for (int i = 1; i <= 5; i++) begin
         send_b(8'(i), 1'b0, wt);
         repeat (3) @(negedge clk);
         if (i >= 3) check_eq("t3_fill_after_xfer", 144'(b_fill_level), 144'd2);
         @(posedge clk); #1;
      end

      // Back-pressure: held window, full shift register, then release
      do_reset();
      a_out_ready = 1'b0;
      for (int i = 1; i <= 9; i++) send_a(16'(i), 1'b0, wt);
      tot = 0;
      for (int i = 10; i <= 18; i++) begin
         send_a(16'(i), 1'b0, wt);
         tot += wt;
      end
      check_eq("t4_fill_no_stall", 144'(tot), 144'd0);
      a_in_valid = 1'b1; a_in_data = 16'd19;
      repeat (3) begin
         @(negedge clk);
         check_eq("t4_in_ready_low", 144'(a_in_ready), 144'd0);
         check_eq("t4_held_valid", 144'(a_out_valid), 144'd1);
         check_eq("t4_held_data", a_out_data, pack_a(1));
      end
      @(posedge clk); #1;
      a_out_ready = 1'b1;
      send_a(16'd19, 1'b0, wt);
      check_eq("t4_release_accept", 144'(wt), 144'd0);
      @(negedge clk);
      check_eq("t4_next_window_valid", 144'(a_out_valid), 144'd1);
      @(posedge clk); #1;
      for (int i = 20; i <= 27; i++) send_a(16'(i), 1'b0, wt);
      repeat (5) @(posedge clk);

      // Partial frame: zero padding and frame-final window
      #1;
      for (int i = 1; i <= 3; i++) send_a(16'(i), 1'b0, wt);
      send_a(16'd4, 1'b1, wt);
      repeat (6) begin
         @(negedge clk);
         check_eq("t5_pad_in_ready", 144'(a_in_ready), 144'd0);
      end
      @(posedge clk); #1;
      send_a(16'd100, 1'b0, wt);
      check_eq("t5_next_frame_accept", 144'(wt), 144'd0);
      @(negedge clk);
      check_eq("t5_fill_new_frame", 144'(a_fill_level), 144'd1);

      // Reset mid-window and mid-pad, clear mid-window, then a clean window
      @(posedge clk); #1;
      for (int i = 1; i <= 5; i++) send_a(16'(50 + i), 1'b0, wt);
      do_reset();
      send_a(16'd1, 1'b0, wt);
      send_a(16'd2, 1'b1, wt);
      @(negedge clk); @(negedge clk);
      do_reset();
      for (int i = 1; i <= 5; i++) send_a(16'(30 + i), 1'b0, wt);
      a_clear = 1'b1;
      @(posedge clk); #1;
      a_clear = 1'b0;
      ha.delete();
      @(negedge clk);
      check_eq("t6_clear_fill", 144'(a_fill_level), 144'd0);
      @(posedge clk); #1;
      for (int i = 101; i <= 109; i++) send_a(16'(i), 1'b0, wt);
      repeat (6) @(posedge clk);

      check_eq("a_sb_drained", 144'(qa.size()), 144'd0);
      check_eq("b_sb_drained", 144'(qb.size()), 144'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
